// File: rtl/ucode_seq.sv
// Microcode sequencer: owns the micro-PC, decodes the ROM branch field into the
// next address, and drives squash/hold controls for the microcode field register.
module ucode_seq #(
  parameter int ADDR_W   = 9,
  parameter int RS_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              ucode_start,
  input  logic [ADDR_W-1:0] ucode_entry,
  input  logic [11:0]       rom_br,
  input  logic              u_zero,
  input  logic              mem_ack,
  input  logic              ie_stall,
  input  logic              ucode_abort,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              ucode_busy,
  output logic              ucode_done,
  output logic              sel_fxx_default,
  output logic              ie_stall_ucode,
  output logic              rs_err
);

  localparam int SP_W  = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BR_SEQ  = 3'b000,
    BR_JMP  = 3'b001,
    BR_BZ   = 3'b010,
    BR_BNZ  = 3'b011,
    BR_CALL = 3'b100,
    BR_RET  = 3'b101,
    BR_DONE = 3'b110,
    BR_WAIT = 3'b111
  } br_op_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] upc, upc_d, upc_inc, target, stack_top;
  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] stack [RS_DEPTH];
  logic              push, pop, stack_clr, err_set, done_d;
  logic              stack_full, stack_empty;
  br_op_t            br_op;

  assign upc_inc     = upc + ADDR_W'(1);
  assign target      = rom_br[ADDR_W-1:0];
  assign br_op       = br_op_t'(rom_br[11:9]);
  assign stack_full  = (sp == SP_W'(RS_DEPTH));
  assign stack_empty = (sp == '0);
  assign stack_top   = stack[IDX_W'(sp - SP_W'(1))];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    upc_d     = upc;
    push      = 1'b0;
    pop       = 1'b0;
    stack_clr = 1'b0;
    err_set   = 1'b0;
    done_d    = 1'b0;

    if (ucode_abort) begin
      state_d   = S_IDLE;
      stack_clr = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ucode_start) begin
            upc_d   = ucode_entry;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          // A stalled cycle freezes everything, so nothing is decoded here.
          if (!ie_stall) begin
            unique case (br_op)
              BR_SEQ:  upc_d = upc_inc;
              BR_JMP:  upc_d = target;
              BR_BZ:   upc_d = u_zero ? target : upc_inc;
              BR_BNZ:  upc_d = u_zero ? upc_inc : target;
              BR_CALL: begin
                upc_d = target;
                if (stack_full) err_set = 1'b1;
                else            push    = 1'b1;
              end
              BR_RET: begin
                if (stack_empty) begin
                  err_set = 1'b1;
                  upc_d   = upc_inc;
                end else begin
                  pop   = 1'b1;
                  upc_d = stack_top;
                end
              end
              BR_DONE: begin
                done_d    = 1'b1;
                stack_clr = 1'b1;
                state_d   = S_IDLE;
              end
              BR_WAIT: state_d = S_WAIT;
              default: upc_d = upc_inc;
            endcase
          end
        end
        S_WAIT: begin
          if (!ie_stall && mem_ack) begin
            upc_d   = upc_inc;
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= S_IDLE;
      upc        <= '0;
      sp         <= '0;
      rs_err     <= 1'b0;
      ucode_done <= 1'b0;
    end else begin
      state      <= state_d;
      upc        <= upc_d;
      ucode_done <= done_d;
      rs_err     <= rs_err | err_set;
      if (stack_clr)  sp <= '0;
      else if (push)  sp <= sp + SP_W'(1);
      else if (pop)   sp <= sp - SP_W'(1);
    end
  end

  // NOTE: the stack storage is not reset; the pointer alone defines which
  // entries are valid, so the array stays a plain register file.
  always_ff @(posedge clk) begin
    if (push) stack[IDX_W'(sp)] <= upc_inc;
  end

  assign rom_addr        = upc;
  assign ucode_busy      = (state != S_IDLE);
  // Abort squashes the fields in the same cycle it is raised.
  assign sel_fxx_default = (state == S_IDLE) || ucode_abort;
  assign ie_stall_ucode  = (state == S_WAIT) || ((state != S_IDLE) && ie_stall);

endmodule

// File: tb/tb_ucode_seq.sv
// Directed bench for ucode_seq: hand-computed uPC sequences, stack, wait,
// stall, done and abort behaviour.
module tb_ucode_seq;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset_l;
  logic              ucode_start;
  logic [ADDR_W-1:0] ucode_entry;
  logic [11:0]       rom_br;
  logic              u_zero, mem_ack, ie_stall, ucode_abort;
  logic [ADDR_W-1:0] rom_addr;
  logic              ucode_busy, ucode_done, sel_fxx_default, ie_stall_ucode, rs_err;

  int tests = 0;
  int fails = 0;

  ucode_seq #(.ADDR_W(ADDR_W), .RS_DEPTH(2)) dut (
    .clk(clk), .reset_l(reset_l), .ucode_start(ucode_start), .ucode_entry(ucode_entry),
    .rom_br(rom_br), .u_zero(u_zero), .mem_ack(mem_ack), .ie_stall(ie_stall),
    .ucode_abort(ucode_abort), .rom_addr(rom_addr), .ucode_busy(ucode_busy),
    .ucode_done(ucode_done), .sel_fxx_default(sel_fxx_default),
    .ie_stall_ucode(ie_stall_ucode), .rs_err(rs_err)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] SEQ = 3'b000, JMP = 3'b001, BZ = 3'b010, BNZ = 3'b011,
                         CALL = 3'b100, RET = 3'b101, DONE = 3'b110, WAITOP = 3'b111;

  function automatic logic [11:0] br(input logic [2:0] op, input logic [8:0] t);
    return {op, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_l = 1'b0; ucode_start = 1'b0; ucode_entry = '0; rom_br = '0;
    u_zero = 1'b0; mem_ack = 1'b0; ie_stall = 1'b0; ucode_abort = 1'b0;
    tick(); tick();
    check("rst_addr", rom_addr, 9'h000);
    check("rst_busy", ucode_busy, 1'b0);
    check("rst_done", ucode_done, 1'b0);
    check("rst_sel", sel_fxx_default, 1'b1);
    check("rst_stall", ie_stall_ucode, 1'b0);
    check("rst_rserr", rs_err, 1'b0);

    // Start and three sequential steps
    reset_l = 1'b1; ucode_entry = 9'h040; ucode_start = 1'b1; rom_br = br(SEQ, 9'h000);
    tick();
    ucode_start = 1'b0;
    check("start_addr", rom_addr, 9'h040);
    check("start_busy", ucode_busy, 1'b1);
    check("start_sel", sel_fxx_default, 1'b0);
    ucode_start = 1'b1; ucode_entry = 9'h1AA;  // ignored while busy
    tick();
    ucode_start = 1'b0;
    check("seq1", rom_addr, 9'h041);
    tick(); check("seq2", rom_addr, 9'h042);
    tick(); check("seq3", rom_addr, 9'h043);

    // Conditional branches
    rom_br = br(JMP, 9'h041); tick(); check("jmp", rom_addr, 9'h041);
    rom_br = br(BZ, 9'h100); u_zero = 1'b1; tick(); check("bz_taken", rom_addr, 9'h100);
    rom_br = br(JMP, 9'h041); tick();
    rom_br = br(BZ, 9'h100); u_zero = 1'b0; tick(); check("bz_fall", rom_addr, 9'h042);
    rom_br = br(BNZ, 9'h100); u_zero = 1'b0; tick(); check("bnz_taken", rom_addr, 9'h100);
    rom_br = br(JMP, 9'h042); tick();
    rom_br = br(BNZ, 9'h100); u_zero = 1'b1; tick(); check("bnz_fall", rom_addr, 9'h043);

    // Call/return and stack overflow/underflow
    rom_br = br(JMP, 9'h050); tick();
    rom_br = br(CALL, 9'h080); tick(); check("call", rom_addr, 9'h080);
    rom_br = br(RET, 9'h000); tick(); check("ret", rom_addr, 9'h051);
    check("rserr_clean", rs_err, 1'b0);
    rom_br = br(CALL, 9'h0A0); tick();
    rom_br = br(CALL, 9'h0B0); tick();
    rom_br = br(CALL, 9'h0C0); tick();
    check("call_ovf_jump", rom_addr, 9'h0C0);
    check("call_ovf_err", rs_err, 1'b1);
    rom_br = br(RET, 9'h000); tick(); check("ret_inner", rom_addr, 9'h0A1);
    tick(); check("ret_outer", rom_addr, 9'h052);
    tick(); check("ret_underflow", rom_addr, 9'h053);
    check("rserr_sticky", rs_err, 1'b1);

    // Wait for memory; ack on the decode cycle is ignored
    rom_br = br(JMP, 9'h060); tick();
    rom_br = br(WAITOP, 9'h000); mem_ack = 1'b1; tick();
    mem_ack = 1'b0;
    check("wait_hold1", rom_addr, 9'h060);
    check("wait_stall", ie_stall_ucode, 1'b1);
    tick(); check("wait_hold2", rom_addr, 9'h060);
    tick(); check("wait_hold3", rom_addr, 9'h060);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    check("wait_ack", rom_addr, 9'h061);
    check("wait_release", ie_stall_ucode, 1'b0);

    // IE stall over a wrapping sequential step
    rom_br = br(JMP, 9'h1FF); tick();
    rom_br = br(SEQ, 9'h000); ie_stall = 1'b1; #1;
    check("iestall_out", ie_stall_ucode, 1'b1);
    tick(); check("iestall_hold1", rom_addr, 9'h1FF);
    tick(); check("iestall_hold2", rom_addr, 9'h1FF);
    ie_stall = 1'b0; tick(); check("seq_wrap", rom_addr, 9'h000);

    // DONE under stall, then released
    rom_br = br(DONE, 9'h000); ie_stall = 1'b1; tick();
    check("done_stalled", ucode_done, 1'b0);
    check("done_stalled_busy", ucode_busy, 1'b1);
    ie_stall = 1'b0; tick();
    check("done_pulse", ucode_done, 1'b1);
    check("done_busy", ucode_busy, 1'b0);
    check("done_sel", sel_fxx_default, 1'b1);
    tick(); check("done_single", ucode_done, 1'b0);

    // Abort during WAIT together with start
    ucode_entry = 9'h060; ucode_start = 1'b1; tick(); ucode_start = 1'b0;
    rom_br = br(WAITOP, 9'h000); tick();
    check("abort_pre_wait", ie_stall_ucode, 1'b1);
    ucode_abort = 1'b1; ucode_start = 1'b1; ucode_entry = 9'h123; #1;
    check("abort_sel_comb", sel_fxx_default, 1'b1);
    tick();
    ucode_abort = 1'b0; ucode_start = 1'b0;
    check("abort_idle", ucode_busy, 1'b0);
    check("abort_no_done", ucode_done, 1'b0);
    check("abort_start_drop", rom_addr, 9'h060);
    tick();
    check("abort_stays_idle", ucode_busy, 1'b0);
    check("abort_rserr_kept", rs_err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
